// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the LFSR datapath: accepts a tap/seed/length configuration,
// issues a one-cycle load, then paces step strobes from a clock divider.
module lfsr_run_ctrl #(
  parameter int unsigned CLOCK_HZ = 1000000,
  parameter int unsigned STEP_HZ  = 1,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [15:0]      cfg_steps,
  input  logic             abort,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_taps,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      step_count
);

  localparam int unsigned DIV  = CLOCK_HZ / STEP_HZ;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("lfsr_run_ctrl: CLOCK_HZ / STEP_HZ must be at least 1");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [15:0]      steps_q, steps_d;
  logic [15:0]      count_q, count_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             tick;
  logic             finished;

  assign accept   = cfg_valid && ready_q;
  assign tick     = (div_q == DivLast);
  assign finished = (steps_q != 16'd0) && (count_q == steps_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    taps_d  = taps_q;
    seed_d  = seed_q;
    steps_d = steps_q;
    count_d = count_q;
    err_d   = err_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (cfg_taps == '0) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b0;
            taps_d  = cfg_taps;
            seed_d  = (cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
            steps_d = cfg_steps;
            count_d = 16'd0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        div_d   = '0;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (finished) begin
          // Final strobe was issued last cycle; done follows it by one cycle.
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            // Strobe is registered, so it appears the cycle after terminal count.
            step_d  = 1'b1;
            count_d = count_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) || (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      taps_q  <= '0;
      seed_q  <= '0;
      steps_q <= 16'd0;
      count_q <= 16'd0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      taps_q  <= taps_d;
      seed_q  <= seed_d;
      steps_q <= steps_d;
      count_q <= count_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign lfsr_load  = (state_q == StLoad);
  assign busy       = (state_q == StLoad) || (state_q == StRun);
  assign lfsr_step  = step_q;
  assign done       = done_q;
  assign err        = err_q;
  assign lfsr_taps  = taps_q;
  assign lfsr_seed  = seed_q;
  assign step_count = count_q;

endmodule
